// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: request handshake, busy mirror, stalls, HI/LO writes.
// Optional stall performance counter enabled by defining MD_PERF_CNT_EN.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        interrupt,
  input  logic        md_ack,
  output logic        md_req,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_wr_en,
  output logic        md_wr_hi,
  output logic [31:0] md_wr_data,
  output logic        md_rd_hi,
  output logic        stall,
  output logic        busy,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5;
  localparam logic [3:0] OP_MTHI = 4'd7;
  localparam logic [3:0] OP_MTLO = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_arith;
  logic             is_md;

  // Instruction class decode, qualified by e_valid
  always_comb begin
    is_arith = 1'b0;
    is_md    = 1'b0;
    if (e_valid) begin
      is_arith = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
      is_md    = (e_op >= OP_MULT) && (e_op <= OP_MTLO);
    end
  end

  assign busy       = (state != S_IDLE);
  assign stall      = busy && is_md && !interrupt;
  assign md_wr_en   = e_valid && ((e_op == OP_MTHI) || (e_op == OP_MTLO)) && !busy && !interrupt;
  assign md_wr_hi   = (e_op == OP_MTHI);
  assign md_wr_data = e_rs;
  assign md_rd_hi   = (e_op == OP_MFHI);

  // Handshake FSM; an ack in the same cycle as an interrupt still commits the operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      md_req <= 1'b0;
      md_op  <= 2'd0;
      md_a   <= 32'd0;
      md_b   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_arith && !interrupt) begin
            state  <= S_REQ;
            md_req <= 1'b1;
            md_op  <= 2'(e_op - OP_MULT);
            md_a   <= e_rs;
            md_b   <= e_rt;
          end
        end
        S_REQ: begin
          if (md_ack) begin
            state  <= S_WAIT;
            md_req <= 1'b0;
            cnt    <= md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
          end else if (interrupt) begin
            state  <= S_IDLE;
            md_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          md_req <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Free-running count of stalled cycles, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        interrupt;
  logic        md_ack;
  logic        md_req;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_wr_en;
  logic        md_wr_hi;
  logic [31:0] md_wr_data;
  logic        md_rd_hi;
  logic        stall;
  logic        busy;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .e_valid        (e_valid),
    .e_op           (e_op),
    .e_rs           (e_rs),
    .e_rt           (e_rt),
    .interrupt      (interrupt),
    .md_ack         (md_ack),
    .md_req         (md_req),
    .md_op          (md_op),
    .md_a           (md_a),
    .md_b           (md_b),
    .md_wr_en       (md_wr_en),
    .md_wr_hi       (md_wr_hi),
    .md_wr_data     (md_wr_data),
    .md_rd_hi       (md_rd_hi),
    .stall          (stall),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending request plus the index of the last busy cycle
  bit          m_req;
  logic [1:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          cyc;
  int          busy_end;
  logic [31:0] m_perf;
  logic        seen_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_req    = 1'b0;
    m_op     = 2'd0;
    m_a      = 32'd0;
    m_b      = 32'd0;
    cyc      = 0;
    busy_end = -1;
    m_perf   = 32'd0;
  endtask

  function automatic bit m_busy();
    return m_req || (cyc <= busy_end);
  endfunction

  function automatic bit is_arith_in();
    return e_valid && (e_op >= 4'd1) && (e_op <= 4'd4);
  endfunction

  function automatic bit exp_stall();
    return m_busy() && e_valid && (e_op >= 4'd1) && (e_op <= 4'd8) && !interrupt;
  endfunction

  task automatic check_outputs();
    bit b;
    b = m_busy();
    check("md_req", 32'(md_req), 32'(m_req));
    check("md_op", 32'(md_op), 32'(m_op));
    check("md_a", md_a, m_a);
    check("md_b", md_b, m_b);
    check("busy", 32'(busy), 32'(b));
    check("stall", 32'(stall), 32'(exp_stall()));
    check("md_wr_en", 32'(md_wr_en),
          32'(e_valid && (e_op == 4'd7 || e_op == 4'd8) && !b && !interrupt));
    check("md_wr_hi", 32'(md_wr_hi), 32'(e_op == 4'd7));
    check("md_wr_data", md_wr_data, e_rs);
    check("md_rd_hi", 32'(md_rd_hi), 32'(e_op == 4'd5));
`ifdef MD_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, m_perf);
`else
    check("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
  endtask

  task automatic model_update();
    if (exp_stall()) m_perf = m_perf + 32'd1;
    if (m_req) begin
      if (md_ack) begin
        m_req    = 1'b0;
        busy_end = cyc + ((m_op >= 2'd2) ? 10 : 5);
      end else if (interrupt) begin
        m_req = 1'b0;
      end
    end else if (!m_busy() && is_arith_in() && !interrupt) begin
      m_req = 1'b1;
      m_op  = 2'(e_op - 4'd1);
      m_a   = e_rs;
      m_b   = e_rt;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    seen_stall = stall;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic intr, input logic ack);
    e_valid   = v;
    e_op      = op;
    e_rs      = rs;
    e_rt      = rt;
    interrupt = intr;
    md_ack    = ack;
  endtask

  initial begin
    int stall_len;
    logic [31:0] perf_base;

    reset = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // MULT 3*7 with immediate ack, MFHI right behind it
    drive(1'b1, 4'd1, 32'd3, 32'd7, 1'b0, 1'b0);
    step();
    check("mult_a", md_a, 32'd3);
    check("mult_b", md_b, 32'd7);
    check("mult_op", 32'(md_op), 32'd0);
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    stall_len = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      stall_len += int'(seen_stall);
      md_ack = 1'b0;
    end
    check("mfhi_stall_len", 32'(stall_len), 32'd6);
    check("mfhi_rd_hi", 32'(md_rd_hi), 32'd1);

    // DIVU with ack withheld three cycles, then MTLO 0xAA
    drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd8, 32'hAA, 32'd0, 1'b0, 1'b0);
    repeat (3) step();
    md_ack = 1'b1;
    step();
    md_ack = 1'b0;
    stall_len = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      stall_len += int'(seen_stall);
    end
    check("mtlo_stall_len", 32'(stall_len), 32'd10);
    @(negedge clk);
    check("mtlo_wr_en", 32'(md_wr_en), 32'd1);
    check("mtlo_wr_hi", 32'(md_wr_hi), 32'd0);
    check("mtlo_wr_data", md_wr_data, 32'hAA);
    @(posedge clk);
    model_update();
    #1;

    // DIV cancelled by interrupt, then DIV whose ack beats the interrupt
    drive(1'b1, 4'd3, 32'd9, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("cancel_req", 32'(md_req), 32'd0);
    check("cancel_busy", 32'(busy), 32'd0);
    drive(1'b1, 4'd3, 32'd9, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 4'd1, 32'd1, 32'd1, 1'b1, 1'b0);
    repeat (10) step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();

    // MTHI in idle, then the same with an interrupt
    drive(1'b1, 4'd7, 32'h5555_AAAA, 32'd0, 1'b0, 1'b0);
    step();
    interrupt = 1'b1;
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();

    // Back-to-back MULTs, immediate ack: six stalled cycles
    perf_base = perf_stall_cnt;
    drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd2, 32'd4, 32'd5, 1'b0, 1'b1);
    repeat (6) step();
    md_ack = 1'b0;
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
`ifdef MD_PERF_CNT_EN
    check("perf_delta", perf_stall_cnt - perf_base, 32'd6);
`else
    check("perf_delta", perf_stall_cnt, 32'd0);
`endif
    repeat (6) step();

    // Asynchronous reset mid-request
    drive(1'b1, 4'd1, 32'h1234, 32'd5, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_a", md_a, 32'h1234);
    #2 reset = 1'b0;
    #1;
    check("rst_md_req", 32'(md_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_md_a", md_a, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) < 2));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit. It sits in the E stage between the decoded instruction and the MD unit's request/acknowledge interface.
- Issues MULT/MULTU/DIV/DIVU requests with registered operands and drives MTHI/MTLO writes.
- Mirrors the unit's busy window, stalls any dependent MD instruction, and cancels unacknowledged requests on interrupt.

Parameters:
- MUL_CYC, 5, busy cycles after acknowledge for MULT/MULTU.
- DIV_CYC, 10, busy cycles after acknowledge for DIV/DIVU.
- CNT_W, 4, width of the internal busy counter. Must hold max(MUL_CYC, DIV_CYC).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- e_valid  in  1  E-stage instruction valid
- e_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others are treated as NONE
- e_rs  in  32  rs operand, already forwarded
- e_rt  in  32  rt operand, already forwarded
- interrupt  in  1  exception/interrupt flush of the E stage this cycle
- md_ack  in  1  MD unit accepts the request
- md_req  out  1  request valid
- md_op  out  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- md_a  out  32  operand A
- md_b  out  32  operand B
- md_wr_en  out  1  HI/LO write strobe
- md_wr_hi  out  1  1 = write HI, 0 = write LO
- md_wr_data  out  32  HI/LO write data (equals e_rs)
- md_rd_hi  out  1  read-mux select: 1 = HI, 0 = LO
- stall  out  1  freeze F/D/E
- busy  out  1  state != IDLE

Behaviour:
- State machine: IDLE, REQ, WAIT. The state register is updated on the clk rising edge.
- Reset (reset = 0, asynchronous):
  - state = IDLE, cnt = 0.
  - md_req, md_op, md_a, md_b = 0.
  - stall, busy, md_wr_en = 0.
- Classes: "arith" = e_op 1-4; "any MD" = e_op 1-8. The class is evaluated only when e_valid = 1.
- IDLE:
  - arith && !interrupt → latch md_op = e_op-1, md_a = e_rs, md_b = e_rt; next state REQ.
  - The issuing instruction itself is not stalled.
- REQ:
  - md_req = 1; md_op, md_a and md_b stay stable until acknowledged.
  - md_ack = 1 → WAIT, cnt = MUL_CYC for op 0/1, DIV_CYC for op 2/3.
  - interrupt = 1 with md_ack = 0 → IDLE; md_req is low in the next cycle (request cancelled).
  - interrupt = 1 with md_ack = 1 in the same cycle → the ack wins and the state goes to WAIT, because the unit has already committed.
- WAIT:
  - md_req = 0; cnt decrements each cycle.
  - When cnt == 1 → IDLE next cycle, with cnt = 0.
  - interrupt does not affect WAIT; an accepted operation always completes.
- stall = busy && e_valid && any MD && !interrupt. It is combinational, with no extra latency.
  - A back-to-back MULT, or an MFHI after a MULT, stalls from the cycle after issue until the cycle the state returns to IDLE.
  - Non-MD instructions never stall.
- md_wr_en = e_valid && (e_op == 7 || e_op == 8) && !busy && !interrupt. It is combinational.
  - md_wr_hi = (e_op == 7); md_wr_data = e_rs.
  - An MTHI/MTLO while busy is stalled rather than written.
- md_rd_hi = (e_op == 5). It is combinational and meaningful only when the instruction is not stalled.
- Divide by zero:
  - No special handling; it is issued and counted as DIV_CYC.
  - The unit leaves HI/LO unchanged.
- Operands are captured only on the IDLE→REQ transition. Later changes to e_rs or e_rt are ignored.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- When defined:
  - Adds output perf_stall_cnt[31:0], which increments on every cycle with stall = 1.
  - It wraps from 0xFFFFFFFF to 0 and is cleared by reset.
- When undefined:
  - The port still exists and is tied to 0.
  - No counter flops are built.

Test Plan:
- Reset pulsed low mid-REQ (md_a = 0x1234) → md_req, busy, md_a and stall go to 0 immediately; the state after release is IDLE.
- MULT with rs = 3, rt = 7, md_ack = 1 in the first REQ cycle → md_a = 3, md_b = 7, md_op = 0. busy stays high for 1 REQ + 5 WAIT cycles. An MFHI presented right after the MULT stalls for exactly those 6 cycles, then proceeds with md_rd_hi = 1.
- DIVU with md_ack withheld 3 cycles → md_req is held for 3 cycles with stable operands, then DIV_CYC = 10 WAIT cycles. A following MTLO with rs = 0xAA stalls, then md_wr_en = 1, md_wr_hi = 0, md_wr_data = 0xAA.
- DIV issued, interrupt in the first REQ cycle with md_ack = 0 → next cycle IDLE, md_req = 0, no stall. Repeat with md_ack = 1 in the same cycle → the state enters WAIT and completes 10 cycles.
- MTHI in IDLE with no stall → md_wr_en pulses for 1 cycle with md_wr_hi = 1. The same instruction with interrupt = 1 → md_wr_en = 0.
- MD_PERF_CNT_EN defined; two back-to-back MULTs with immediate ack → perf_stall_cnt = 6 after the second issues. With the macro undefined, perf_stall_cnt stays 0.
